jk_ff_driver: RTL and testbench
===============================

# jk_ff_driver

Stimulus-side companion to the JK flip-flop. It takes a stream of target Q bits over a valid/ready interface and buffers them in a small FIFO. For each target it computes the J/K excitation from the tracked flip-flop state and drives it one target per clock. It then checks the flip-flop's returned `q` against the expected value two cycles later and keeps a sticky error flag and a mismatch count.

## Interface
Parameters:
- `DEPTH`, default 8: target FIFO depth; must be a power of two, at least 2.
- `CNT_W`, default 8: width of `err_cnt`.

Ports:
- `clk` input, 1: single clock; all state changes on the rising edge.
- `rst` input, 1: reset, synchronous and active-high. Must be asserted together with the driven flip-flop's `rst`.
- `in_valid` input, 1: a target bit is offered.
- `in_bit` input, 1: target next-state Q.
- `in_ready` output, 1: the FIFO can accept a bit (`!full`).
- `j` output, 1: registered J drive to the flip-flop.
- `k` output, 1: registered K drive to the flip-flop.
- `q_fb` input, 1: `q` returned from the flip-flop.
- `exp_q` output, 1: tracked (expected) flip-flop state after the most recent issued target.
- `busy` output, 1: FIFO non-empty, or any issued target still awaiting its check.
- `err` output, 1: sticky; set on the first mismatch.
- `err_cnt` output, `CNT_W`: number of mismatches, saturating at all-ones.

## Operation
- Reset values: `j`=0, `k`=0, `in_ready`=1, `exp_q`=0, `busy`=0, `err`=0, `err_cnt`=0. The FIFO is emptied and the check pipeline cleared.
- Push: `in_valid && in_ready` writes `in_bit` to the FIFO.
  - A push while full cannot occur, because `in_ready` is low.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- Issue: each cycle the FIFO is non-empty, one entry `t` is popped and the excitation is registered from current `exp_q`:
  - `exp_q`=0, `t`=0: `j`=0, `k`=0.
  - `exp_q`=0, `t`=1: `j`=1, `k`=0.
  - `exp_q`=1, `t`=0: `j`=0, `k`=1.
  - `exp_q`=1, `t`=1: `j`=0, `k`=0.
  - `exp_q` is then updated to `t`.
- FIFO empty: `j`=0, `k`=0 (hold). No check slot is issued and `exp_q` is unchanged.
- Check pipeline: a 2-stage shift of {valid, expected}.
  - When a stage-2 entry is valid and `q_fb` differs from its expected value: set `err` and increment `err_cnt` (saturating).
  - Non-issued cycles produce no check.
- FIFO pointers are `$clog2(DEPTH)`+1 bits wide; full/empty are decided by the MSB-differ / all-equal rule and wrap naturally.
- `busy` = FIFO non-empty OR either pipeline stage valid.
- Reset mid-operation: all queued and in-flight targets are discarded with no check. `err` and `err_cnt` are cleared.

## Timing
- Push at edge N, FIFO previously empty → popped at edge N+1, so `j`/`k` are valid after N+1.
  - The flip-flop samples them at edge N+2.
  - The comparison against `q_fb` happens at edge N+3, so `err` is visible after N+3.
- Throughput is one target per clock. Push-to-`j/k` latency is 1 cycle through an empty FIFO.
- `in_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.

## Configuration
- `JK_DRIVER_TOGGLE_EN`:
  - Defined: a state change (`exp_q` != `t`) is driven with `j`=1, `k`=1 (toggle) instead of set/reset. Hold cases are unchanged.
  - Undefined: set/reset encoding as listed under Operation.
- The check logic is identical in both builds.

## Test plan
- Reset then idle 5 cycles → `j`=`k`=0, `in_ready`=1, `busy`=0, `err`=0, `err_cnt`=0.
- Push 1,1,0,0,1 back-to-back with a correct flip-flop → j/k sequence (1,0),(0,0),(0,1),(0,0),(1,0); `q_fb` follows; `err`=0; `busy` drops 3 cycles after the last push.
- Hold `q_fb` stuck at 0 and push 1,0,1 → `err`=1 at the first check; `err_cnt`=2.
- Push `DEPTH`+2 bits with `in_valid` held high for `DEPTH`+2 cycles → no bit is lost, order is preserved, and `in_ready` never reads low while a pop is occurring in the same cycle.
- Assert `rst` for one cycle with 4 targets queued → next cycle `busy`=0, `j`=`k`=0, `exp_q`=0, no stale check fires.
- With `JK_DRIVER_TOGGLE_EN` defined, push 1,0 → j/k (1,1),(1,1); `err`=0.

Source files
------------

// File: rtl/jk_ff_driver.sv
// jk_ff_driver: FIFO-buffered J/K excitation driver that checks the flip-flop's q two cycles after issue.
// Optional JK_DRIVER_TOGGLE_EN drives state changes as toggles (j=k=1) instead of set/reset.
module jk_ff_driver #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             exp_q,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem_q;
    logic [AW:0] wr_q, rd_q;
    logic j_q, k_q, j_d, k_d, exp_q_q, v1_q, e1_q, v2_q, e2_q, err_q;
    logic [CNT_W-1:0] cnt_q;
    logic empty, full, push, pop, t, mis;
    assign empty    = wr_q == rd_q;
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push     = in_valid && !full;
    assign pop      = !empty;
    assign t        = mem_q[rd_q[AW-1:0]];
    assign mis      = v2_q && (q_fb != e2_q);
    assign in_ready = !full;
    assign j        = j_q;
    assign k        = k_q;
    assign exp_q    = exp_q_q;
    assign busy     = !empty || v1_q || v2_q;
    assign err      = err_q;
    assign err_cnt  = cnt_q;
    always_comb begin
`ifdef JK_DRIVER_TOGGLE_EN
        j_d = pop && (exp_q_q != t);
        k_d = pop && (exp_q_q != t);
`else
        j_d = pop && !exp_q_q && t;
        k_d = pop && exp_q_q && !t;
`endif
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= in_bit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            exp_q_q <= 1'b0;
            v1_q    <= 1'b0;
            e1_q    <= 1'b0;
            v2_q    <= 1'b0;
            e2_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (pop) exp_q_q <= t;
            j_q  <= j_d;
            k_q  <= k_d;
            v1_q <= pop;
            e1_q <= t;
            v2_q <= v1_q;
            e2_q <= e1_q;
            // Sticky flag plus saturating mismatch counter
            if (mis) err_q <= 1'b1;
            if (mis && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_jk_ff_driver.sv
// tb_jk_ff_driver: scoreboard bench for jk_ff_driver driving a behavioural JK flip-flop.
module tb_jk_ff_driver;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_bit = 1'b0;
    logic in_ready, j, k, exp_q, busy, err, q_fb, q_ff = 1'b0, stuck = 1'b0;
    logic [CNT_W-1:0] err_cnt;
    int errors = 0, checks = 0;
    logic [2:0] sb[$];
    logic m_tail = 1'b0, m_exp = 1'b0, m_v1 = 1'b0, m_e1 = 1'b0, m_v2 = 1'b0, m_e2 = 1'b0, m_err = 1'b0;
    int m_cnt = 0;

    jk_ff_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .j(j), .k(k), .q_fb(q_fb), .exp_q(exp_q), .busy(busy), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) q_ff <= rst ? 1'b0 : (j && k) ? ~q_ff : j ? 1'b1 : k ? 1'b0 : q_ff;
    assign q_fb = stuck ? 1'b0 : q_ff;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic b);
        logic pu, po, jj, kk;
        logic [2:0] e;
        @(negedge clk);
        rst = r;
        in_valid = v;
        in_bit = b;
        if (!r) check("in_ready", in_ready, sb.size() < DEPTH);
        pu = v && !r && sb.size() < DEPTH;
        po = !r && sb.size() > 0;
        if (!r && m_v2 && q_fb !== m_e2) begin
            m_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        if (pu) begin
`ifdef JK_DRIVER_TOGGLE_EN
            jj = m_tail != b;
            kk = m_tail != b;
`else
            jj = !m_tail && b;
            kk = m_tail && !b;
`endif
            sb.push_back({jj, kk, b});
            m_tail = b;
        end
        e = po ? sb.pop_front() : 3'b000;
        m_v2 = m_v1;
        m_e2 = m_e1;
        m_v1 = po;
        m_e1 = e[0];
        if (po) m_exp = e[0];
        if (r) begin
            sb.delete();
            {m_tail, m_exp, m_v1, m_v2, m_err} = '0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        check("j", j, e[2]);
        check("k", k, e[1]);
        check("exp_q", exp_q, m_exp);
        check("busy", busy, sb.size() > 0 || m_v1 || m_v2);
        check("err", err, m_err);
        check("err_cnt", err_cnt, m_cnt);
    endtask

    initial begin
        logic [4:0] pat;
        pat = 5'b10011;
        repeat (2) cycle(1, 0, 0);
        repeat (5) cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, pat[i]);
        repeat (4) cycle(0, 0, 0);
        check("busy_idle", busy, 1'b0);
        stuck = 1'b1;
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        repeat (4) cycle(0, 0, 0);
        check("stuck_err", err, 1'b1);
        check("stuck_cnt", err_cnt, 8'd2);
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 1'(i % 3 == 0));
        repeat (2) cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1);
        cycle(1, 0, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_exp", exp_q, 1'b0);
        repeat (4) cycle(0, 0, 0);
        check("rst_no_stale", err_cnt, 8'd0);
        stuck = 1'b0;
        cycle(0, 1, 1);
        cycle(0, 1, 0);
        repeat (4) cycle(0, 0, 0);
        for (int i = 0; i < 40; i++) cycle(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        repeat (4) cycle(0, 0, 0);
        check("final_err", err, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
